// File: rtl/sumador_pkg.sv
// rtl/sumador_pkg.sv - shared flag positions and types for the pipelined adder
package sumador_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] flags_t;

endpackage

// File: rtl/sumador_etapa.sv
// rtl/sumador_etapa.sv - combinational SLICE-bit carry-chain adder for one pipeline stage
module sumador_etapa #(
    parameter int SLICE = 16
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    // Only carry chain in a stage: SLICE bits wide
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};

endmodule

// File: rtl/sumador_segmentado.sv
// rtl/sumador_segmentado.sv - pipelined adder/subtractor with valid/ready, flush and NZCV flags
module sumador_segmentado #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vaciar,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operando_a,
    input  logic [WIDTH-1:0] operando_b,
    input  logic             resta,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] salida,
    output logic [3:0]       banderas
);
    import sumador_pkg::*;

    localparam int SLICE = WIDTH / STAGES;

    // Stage s owns slice s. Its inputs are the still-unprocessed upper slices
    // (UW bits) and the already-finished lower sum slices (LW bits).
    for (genvar s = 0; s < STAGES; s++) begin : etapa
        localparam int UW = WIDTH - s * SLICE;
        localparam int LW = s * SLICE;

        logic [UW-1:0]       a_in;
        logic [UW-1:0]       b_in;
        logic                c_in;
        logic                v_in;
        logic                rdy;
        logic                v_q;
        logic                cout;
        logic [SLICE-1:0]    suma;
        logic [LW+SLICE-1:0] sum_d;
        logic [LW+SLICE-1:0] sum_q;

        if (s == 0) begin : g_ent
            assign a_in  = operando_a;
            assign b_in  = resta ? ~operando_b : operando_b;
            assign c_in  = resta;
            assign v_in  = in_valid && in_ready;
            assign sum_d = suma;
        end else begin : g_enc
            assign a_in  = etapa[s-1].g_skew.a_q;
            assign b_in  = etapa[s-1].g_skew.b_q;
            assign c_in  = etapa[s-1].g_skew.c_q;
            assign v_in  = etapa[s-1].v_q;
            assign sum_d = {suma, etapa[s-1].sum_q};
        end

        sumador_etapa #(.SLICE(SLICE)) u_suma (
            .a   (a_in[SLICE-1:0]),
            .b   (b_in[SLICE-1:0]),
            .cin (c_in),
            .sum (suma),
            .cout(cout)
        );

        // A stage may advance when empty or when the next one advances
        if (s == STAGES - 1) begin : g_rdy
            assign rdy = !v_q || out_ready;
        end else begin : g_rdy
            assign rdy = !v_q || etapa[s+1].rdy;
        end

        // Valid bit and deskewed sum; flush clears valid but leaves data stale
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                sum_q <= '0;
            end else if (vaciar) begin
                v_q <= 1'b0;
            end else if (rdy) begin
                v_q <= v_in;
                if (v_in) begin
                    sum_q <= sum_d;
                end
            end
        end

        if (s < STAGES - 1) begin : g_skew
            logic [UW-SLICE-1:0] a_q;
            logic [UW-SLICE-1:0] b_q;
            logic                c_q;

            // Skew registers: upper operand slices and the carry into the next slice
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    c_q <= 1'b0;
                end else if (!vaciar && rdy && v_in) begin
                    a_q <= a_in[UW-1:SLICE];
                    b_q <= b_in[UW-1:SLICE];
                    c_q <= cout;
                end
            end
        end else begin : g_fin
            flags_t f_d;
            flags_t flags_q;

            // Flags from the complete result; operand MSBs are in this stage's slice
            always_comb begin
                f_d         = '0;
                f_d[FLAG_N] = sum_d[WIDTH-1];
                f_d[FLAG_Z] = (sum_d == '0);
                f_d[FLAG_C] = cout;
                f_d[FLAG_V] = (a_in[SLICE-1] == b_in[SLICE-1]) &&
                              (sum_d[WIDTH-1] != a_in[SLICE-1]);
            end

            // Flags register alongside the final sum
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    flags_q <= '0;
                end else if (!vaciar && rdy && v_in) begin
                    flags_q <= f_d;
                end
            end
        end
    end

    assign in_ready  = etapa[0].rdy && !vaciar;
    assign out_valid = etapa[STAGES-1].v_q;
    assign salida    = etapa[STAGES-1].sum_q;
    assign banderas  = etapa[STAGES-1].g_fin.flags_q;

endmodule
